// File: rtl/register_file_sb.sv
// Parametrised register file with a hardware clear sequencer and a per-register
// pending-write scoreboard used by decode for RAW hazard detection.
module register_file_sb #(
    parameter int XLEN   = 32,
    parameter int AW     = 5,
    parameter bit BYPASS = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we3,
    input  logic [AW-1:0]   wa3,
    input  logic [XLEN-1:0] wd3,
    input  logic [AW-1:0]   ra1,
    input  logic [AW-1:0]   ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rd,
    output logic            pend1,
    output logic            pend2,
    output logic            ready
);

    localparam int NREGS = 2 ** AW;

    typedef enum logic {
        CLEAR,
        RUN
    } state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     clrIdx_q, clrIdx_d;
    logic [NREGS-1:0]  pend_q, pend_d;
    logic [XLEN-1:0]   regs_q [NREGS];

    logic              regWe;
    logic [AW-1:0]     regWa;
    logic [XLEN-1:0]   regWd;
    logic              running;
    logic              hit1, hit2;

    // During CLEAR the sequencer owns the write port; in RUN writeback does.
    always_comb begin
        state_d  = state_q;
        clrIdx_d = clrIdx_q;
        pend_d   = pend_q;
        regWe    = 1'b0;
        regWa    = wa3;
        regWd    = wd3;
        case (state_q)
            CLEAR: begin
                regWe    = 1'b1;
                regWa    = clrIdx_q;
                regWd    = '0;
                clrIdx_d = clrIdx_q + 1'b1;
                if (clrIdx_q == AW'(NREGS - 1)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                regWe = we3 && (wa3 != '0);
                if (we3) begin
                    pend_d[wa3] = 1'b0;
                end
                // Applied after the clear so a new producer supersedes the retiring one.
                if (iss_valid && (iss_rd != '0)) begin
                    pend_d[iss_rd] = 1'b1;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= CLEAR;
            clrIdx_q <= '0;
            pend_q   <= '0;
        end else begin
            state_q  <= state_d;
            clrIdx_q <= clrIdx_d;
            pend_q   <= pend_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && regWe) begin
            regs_q[regWa] <= regWd;
        end
    end

    assign running = (state_q == RUN) && !reset;
    assign ready   = running;
    assign hit1    = BYPASS && we3 && (wa3 == ra1);
    assign hit2    = BYPASS && we3 && (wa3 == ra2);

    // A forwarded writeback both supplies the data and hides the retiring pending bit.
    always_comb begin
        rd1   = '0;
        rd2   = '0;
        pend1 = 1'b0;
        pend2 = 1'b0;
        if (running && (ra1 != '0)) begin
            rd1   = hit1 ? wd3 : regs_q[ra1];
            pend1 = pend_q[ra1] && !hit1;
        end
        if (running && (ra2 != '0)) begin
            rd2   = hit2 ? wd3 : regs_q[ra2];
            pend2 = pend_q[ra2] && !hit2;
        end
    end

endmodule

// File: tb/tb_register_file_sb.sv
// Bench for register_file_sb: drives a BYPASS=1 and a BYPASS=0 instance with the
// same stimulus and compares both against an array-based reference model.
module tb_register_file_sb;

    localparam int XLEN  = 32;
    localparam int AW    = 5;
    localparam int NREGS = 32;
    localparam int SW    = 2 * XLEN + 3;

    logic            clk = 1'b0;
    logic            reset;
    logic            we3;
    logic [AW-1:0]   wa3;
    logic [XLEN-1:0] wd3;
    logic [AW-1:0]   ra1, ra2;
    logic            iss_valid;
    logic [AW-1:0]   iss_rd;

    logic [XLEN-1:0] rd1B, rd2B, rd1N, rd2N;
    logic            pend1B, pend2B, pend1N, pend2N, readyB, readyN;
    logic [SW-1:0]   obsB, obsN;

    int total = 0;
    int bad   = 0;

    logic [XLEN-1:0] mRegs [NREGS];
    bit              mPend [NREGS];
    bit              mClear = 1'b1;
    int              mIdx   = 0;

    register_file_sb #(.XLEN(XLEN), .AW(AW), .BYPASS(1'b1)) dutB (
        .clk(clk), .reset(reset), .we3(we3), .wa3(wa3), .wd3(wd3),
        .ra1(ra1), .ra2(ra2), .rd1(rd1B), .rd2(rd2B),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .pend1(pend1B), .pend2(pend2B), .ready(readyB)
    );

    register_file_sb #(.XLEN(XLEN), .AW(AW), .BYPASS(1'b0)) dutN (
        .clk(clk), .reset(reset), .we3(we3), .wa3(wa3), .wd3(wd3),
        .ra1(ra1), .ra2(ra2), .rd1(rd1N), .rd2(rd2N),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .pend1(pend1N), .pend2(pend2N), .ready(readyN)
    );

    assign obsB = {readyB, pend1B, pend2B, rd1B, rd2B};
    assign obsN = {readyN, pend1N, pend2N, rd1N, rd2N};

    always #5 clk = ~clk;

    // Reference model: one clock edge applied to the architectural state.
    task automatic modelEdge();
        if (reset) begin
            mClear = 1'b1;
            mIdx   = 0;
            for (int i = 0; i < NREGS; i++) mPend[i] = 1'b0;
        end else if (mClear) begin
            mRegs[mIdx] = '0;
            mIdx++;
            if (mIdx == NREGS) mClear = 1'b0;
        end else begin
            if (we3 && wa3 != 0) mRegs[wa3] = wd3;
            if (we3) mPend[wa3] = 1'b0;
            if (iss_valid && iss_rd != 0) mPend[iss_rd] = 1'b1;
        end
    endtask

    function automatic logic [SW-1:0] expStatus(bit byp);
        bit              run;
        logic [XLEN-1:0] e1, e2;
        bit              p1, p2;
        run = !mClear && !reset;
        e1 = '0; e2 = '0; p1 = 1'b0; p2 = 1'b0;
        if (run && ra1 != 0) begin
            e1 = (byp && we3 && wa3 == ra1) ? wd3 : mRegs[ra1];
            p1 = mPend[ra1] && !(byp && we3 && wa3 == ra1);
        end
        if (run && ra2 != 0) begin
            e2 = (byp && we3 && wa3 == ra2) ? wd3 : mRegs[ra2];
            p2 = mPend[ra2] && !(byp && we3 && wa3 == ra2);
        end
        return {run, p1, p2, e1, e2};
    endfunction

    task automatic tick();
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    task automatic applyStimulus(input bit r, input bit w, input logic [AW-1:0] a,
                                 input logic [XLEN-1:0] d, input logic [AW-1:0] r1,
                                 input logic [AW-1:0] r2, input bit iv, input logic [AW-1:0] ir);
        reset = r; we3 = w; wa3 = a; wd3 = d;
        ra1 = r1; ra2 = r2; iss_valid = iv; iss_rd = ir;
    endtask

    task automatic test_reset();
        applyStimulus(1, 1, 5, 32'hABCD, 5, 7, 1, 7);
        tick();
        #1;
        total++;
        if ({obsB, obsN} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_outputs B=%h N=%h required all zero", obsB, obsN);
        end
        tick();
        total++;
        if (readyB !== 1'b0 || readyN !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_ready B=%b N=%b required 0", readyB, readyN);
        end
    endtask

    task automatic test_clear_latency();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < NREGS; i++) begin
            #1;
            total++;
            if (readyB !== 1'b0 || readyN !== 1'b0) begin
                bad++;
                $display("[TB] FAIL clear_ready_low cycle=%0d B=%b N=%b required 0", i + 1, readyB, readyN);
            end
            tick();
        end
        #1;
        total++;
        if (readyB !== 1'b1 || readyN !== 1'b1) begin
            bad++;
            $display("[TB] FAIL clear_ready_high B=%b N=%b required 1", readyB, readyN);
        end
        for (int r = 0; r < NREGS; r++) begin
            ra1 = AW'(r);
            ra2 = AW'(NREGS - 1 - r);
            #1;
            total++;
            if ({rd1B, rd2B, rd1N, rd2N} !== '0) begin
                bad++;
                $display("[TB] FAIL cleared_read r=%0d B=%h/%h N=%h/%h required 0", r, rd1B, rd2B, rd1N, rd2N);
            end
        end
    endtask

    task automatic test_write_bypass();
        applyStimulus(0, 1, 5, 32'hDEADBEEF, 5, 0, 0, 0);
        #1;
        total++;
        if (rd1B !== 32'hDEADBEEF || rd1N !== 32'h0) begin
            bad++;
            $display("[TB] FAIL bypass_same_cycle B=%h N=%h required DEADBEEF/0", rd1B, rd1N);
        end
        tick();
        applyStimulus(0, 0, 0, 0, 5, 0, 0, 0);
        #1;
        total++;
        if (rd1B !== 32'hDEADBEEF || rd1N !== 32'hDEADBEEF) begin
            bad++;
            $display("[TB] FAIL write_next_cycle B=%h N=%h required DEADBEEF", rd1B, rd1N);
        end
    endtask

    task automatic test_zero_reg();
        applyStimulus(0, 1, 0, 32'h1234, 0, 0, 1, 0);
        #1;
        total++;
        if ({rd2B, rd2N, pend2B, pend2N} !== '0) begin
            bad++;
            $display("[TB] FAIL x0_same_cycle rd2=%h/%h pend2=%b/%b required 0", rd2B, rd2N, pend2B, pend2N);
        end
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        total++;
        if ({rd2B, rd2N, pend2B, pend2N} !== '0) begin
            bad++;
            $display("[TB] FAIL x0_after rd2=%h/%h pend2=%b/%b required 0", rd2B, rd2N, pend2B, pend2N);
        end
    endtask

    task automatic test_scoreboard();
        applyStimulus(0, 0, 0, 0, 7, 0, 1, 7);
        #1;
        total++;
        if (pend1B !== 1'b0 || pend1N !== 1'b0) begin
            bad++;
            $display("[TB] FAIL issue_same_cycle B=%b N=%b required 0", pend1B, pend1N);
        end
        tick();
        applyStimulus(0, 0, 0, 0, 7, 0, 0, 0);
        #1;
        total++;
        if (pend1B !== 1'b1 || pend1N !== 1'b1) begin
            bad++;
            $display("[TB] FAIL issue_next_cycle B=%b N=%b required 1", pend1B, pend1N);
        end
        applyStimulus(0, 1, 7, 32'h77, 7, 0, 0, 0);
        #1;
        total++;
        if (pend1B !== 1'b0 || pend1N !== 1'b1) begin
            bad++;
            $display("[TB] FAIL wb_same_cycle B=%b N=%b required 0/1", pend1B, pend1N);
        end
        tick();
        applyStimulus(0, 0, 0, 0, 7, 0, 0, 0);
        #1;
        total++;
        if (pend1B !== 1'b0 || pend1N !== 1'b0 || rd1B !== 32'h77 || rd1N !== 32'h77) begin
            bad++;
            $display("[TB] FAIL wb_after pend=%b/%b rd=%h/%h required 0/0 77", pend1B, pend1N, rd1B, rd1N);
        end
        applyStimulus(0, 0, 0, 0, 7, 0, 1, 7);
        tick();
        applyStimulus(0, 1, 7, 32'h88, 7, 0, 1, 7);
        tick();
        applyStimulus(0, 0, 0, 0, 7, 0, 1, 7);
        #1;
        total++;
        if (pend1B !== 1'b1 || pend1N !== 1'b1) begin
            bad++;
            $display("[TB] FAIL set_wins B=%b N=%b required 1", pend1B, pend1N);
        end
        tick();
        applyStimulus(0, 1, 7, 32'h99, 0, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 7, 0, 0, 0);
        #1;
        total++;
        if (pend1B !== 1'b0 || pend1N !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reissue_single_clear B=%b N=%b required 0", pend1B, pend1N);
        end
    endtask

    task automatic test_reset_run();
        applyStimulus(0, 1, 3, 32'h55, 0, 0, 1, 9);
        tick();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 9, 3, 0, 0);
        #1;
        total++;
        if ({readyB, readyN, pend1B, pend1N} !== 4'b0) begin
            bad++;
            $display("[TB] FAIL reset_run_state ready=%b/%b pend1=%b/%b required 0", readyB, readyN, pend1B, pend1N);
        end
        for (int i = 0; i < NREGS; i++) begin
            if (i == 1) applyStimulus(0, 1, 4, 32'hAAAA, 9, 3, 1, 4);
            else applyStimulus(0, 0, 0, 0, 9, 3, 0, 0);
            tick();
        end
        applyStimulus(0, 0, 0, 0, 3, 4, 0, 0);
        #1;
        total++;
        if (readyB !== 1'b1 || readyN !== 1'b1 || {rd1B, rd2B, rd1N, rd2N, pend2B, pend2N} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_run_cleared ready=%b/%b x3=%h/%h x4=%h/%h pend2=%b/%b required 1 and 0",
                     readyB, readyN, rd1B, rd1N, rd2B, rd2N, pend2B, pend2N);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            applyStimulus($urandom_range(0, 149) == 0, $urandom_range(0, 1) == 1,
                          AW'($urandom_range(0, 7)), $urandom,
                          AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
                          $urandom_range(0, 1) == 1, AW'($urandom_range(0, 7)));
            if ($urandom_range(0, 9) == 0) ra1 = AW'($urandom);
            #1;
            total++;
            if (obsB !== expStatus(1'b1) || obsN !== expStatus(1'b0)) begin
                bad++;
                $display("[TB] FAIL random n=%0d B=%h N=%h required B=%h N=%h",
                         n, obsB, obsN, expStatus(1'b1), expStatus(1'b0));
            end
            tick();
        end
    endtask

    initial begin
        $display("[TB] register_file_sb bench start");
        test_reset();
        test_clear_latency();
        test_write_bypass();
        test_zero_reg();
        test_scoreboard();
        test_reset_run();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
